// File: rtl/seq_gen_fsm.sv
// Serial frame transmitter: sync pattern, payload MSB first, then idle-zero gap.
// Optional even-parity bit after the payload when SEQ_GEN_PARITY_EN is defined.
module seq_gen_fsm #(
  parameter int unsigned          SYNC_LEN = 7,
  parameter logic [SYNC_LEN-1:0]  SYNC_PAT = 7'b1011010,
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          GAP_LEN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_vld,
  output logic              data_rdy,
  output logic              seq_out,
  output logic              seq_vld,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned MAX_SD  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int unsigned MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  payload_q, payload_d;
  logic               seq_out_q, seq_out_d;
  logic               seq_vld_q, seq_vld_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q;
  logic               data_rdy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    case (state_q)
      ST_IDLE: begin
        if (data_vld) begin
          payload_d = data_in;
          cnt_d     = SYNC_LOAD;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          cnt_d   = DATA_LOAD;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
`ifdef SEQ_GEN_PARITY_EN
          cnt_d   = '0;
          state_d = ST_PAR;
`else
          if (GAP_LEN > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PAR: begin
        if (GAP_LEN > 0) begin
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
`endif
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered bit lines up
  // with the state it belongs to: first sync bit right after the handshake.
  always_comb begin
    seq_out_d    = 1'b0;
    seq_vld_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_d)
      ST_SYNC: begin
        seq_vld_d = 1'b1;
        seq_out_d = SYNC_PAT[cnt_d];
      end
      ST_DATA: begin
        seq_vld_d = 1'b1;
        seq_out_d = payload_d[cnt_d];
`ifndef SEQ_GEN_PARITY_EN
        frame_done_d = (cnt_d == '0);
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PAR: begin
        seq_vld_d    = 1'b1;
        seq_out_d    = ^payload_d;
        frame_done_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      payload_q    <= '0;
      seq_out_q    <= 1'b0;
      seq_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      data_rdy_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      payload_q    <= payload_d;
      seq_out_q    <= seq_out_d;
      seq_vld_q    <= seq_vld_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d != ST_IDLE);
      data_rdy_q   <= (state_d == ST_IDLE);
    end
  end

  assign seq_out    = seq_out_q;
  assign seq_vld    = seq_vld_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign data_rdy   = data_rdy_q;

endmodule
